seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_bcd_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, glyph table and anode helper for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {DARK = 1'b0, ON = 1'b1} scan_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG7_OFF  = 7'h7F;

  // a..g, active-low
  localparam logic [6:0] SEG7_GLYPH [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  function automatic logic [3:0] onehot_an(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to seven-segment (a..g, active-low); codes 10..15 decode to all-off.
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_OFF;
    if (bcd <= 4'd9) seg = SEG7_GLYPH[bcd];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller with dead-time and frame-aligned data update.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 never).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic        upd_ack,
  output logic        frame_done,
  output logic [1:0]  digit_idx,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int NUM_DIGITS = 4;
  localparam int CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK_CYCLES);

  scan_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [NUM_DIGITS-1:0][3:0] act_dig, pend_dig;
  logic [NUM_DIGITS-1:0]      act_dp, pend_dp;
  logic                       pend;
  logic [NUM_DIGITS-1:0][6:0] glyph;
  logic slot_end, wrap, apply;
  logic [7:0] seg_d;
  logic [3:0] an_d;
  logic [1:0] idx_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    logic [6:0] dec;
    seg7_bcd_decode u_dec (.bcd(act_dig[g]), .seg(dec));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // dark when this digit and every digit above it are zero
    logic hi_zero;
    assign hi_zero  = (act_dig >> (4 * g)) == '0;
    assign glyph[g] = (g != 0 && hi_zero) ? SEG7_OFF : dec;
`else
    assign glyph[g] = dec;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DARK;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DARK:    if (en)  state_nx = ON;
      ON:      if (!en) state_nx = DARK;
      default: state_nx = DARK;
    endcase
  end

  assign slot_end = cnt == CNT_LAST;
  assign wrap     = (state_nx == ON) && slot_end && (idx == 2'd3);
  // pending data goes live at the frame wrap, or straight away while dark
  assign apply    = (pend || load) && (wrap || state_nx == DARK);

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'hF;
    idx_d = 2'd0;
    if (state_nx == ON) begin
      idx_d = idx;
      if (cnt >= CNT_LIT) begin
        an_d  = onehot_an(idx);
        seg_d = {glyph[idx], ~act_dp[idx]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      act_dig    <= '0;
      act_dp     <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend       <= 1'b0;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
      digit_idx  <= 2'd0;
      seg        <= SEG_BLANK;
      an         <= 4'hF;
    end else begin
      if (state_nx == ON) begin
        cnt <= slot_end ? '0 : cnt + 1'b1;
        if (slot_end) idx <= idx + 2'd1;
      end else begin
        cnt <= '0;
        idx <= 2'd0;
      end
      if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
        pend     <= 1'b1;
      end
      if (apply) begin
        act_dig <= load ? digits_in : pend_dig;
        act_dp  <= load ? dp_in : pend_dp;
        pend    <= 1'b0;
      end
      upd_ack    <= apply;
      frame_done <= wrap;
      digit_idx  <= idx_d;
      seg        <= seg_d;
      an         <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: glyph table, hand sequences for handshake corners, random run vs position model.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst, en, load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        upd_ack, frame_done;
  logic [1:0]  digit_idx;
  logic [7:0]  seg;
  logic [3:0]  an;

  seg7_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .upd_ack(upd_ack), .frame_done(frame_done), .digit_idx(digit_idx), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int ack_cnt = 0;

  // model: k = en-edges since scanning (re)started; display position before an edge is k
  int          k;
  logic [15:0] m_act, m_pdat;
  logic [3:0]  m_adp, m_pdp;
  logic        m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic [1:0]  e_idx;
  logic        e_ack, e_fd;

  typedef struct packed {
    logic [15:0]      dig;
    logic [3:0]       dp;
    logic [3:0][7:0]  seg;   // expected seg while digit i is lit
  } vec_t;
  vec_t tbl [5];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;  4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;  4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;  4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;  4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;  4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_act = '0; m_pdat = '0; m_adp = '0; m_pdp = '0; m_pend = 1'b0;
    e_seg = 8'hFF; e_an = 4'hF; e_idx = 2'd0; e_ack = 1'b0; e_fd = 1'b0;
  endtask

  task automatic model_edge();
    int p, d;
    logic wrap, apply;
    logic [6:0] g;
    wrap = 1'b0;
    e_seg = 8'hFF; e_an = 4'hF; e_idx = 2'd0;
    if (en) begin
      p = k;
      d = (p / DIV) % 4;
      e_idx = d[1:0];
      wrap = (p % FRAME) == FRAME - 1;
      if (p % DIV >= BLANK) begin
        g = glyph(m_act[4*d +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_act >> (4 * d)) == 16'h0) g = 7'h7F;
`endif
        e_an  = ~(4'b0001 << d);
        e_seg = {g, ~m_adp[d]};
      end
      k++;
    end else k = 0;
    apply = (m_pend || load) && (wrap || !en);
    e_ack = apply;
    e_fd  = wrap;
    if (load) begin m_pdat = digits_in; m_pdp = dp_in; m_pend = 1'b1; end
    if (apply) begin m_act = m_pdat; m_adp = m_pdp; m_pend = 1'b0; end
  endtask

  task automatic check_all();
    chk("seg", 16'(seg), 16'(e_seg));
    chk("an", 16'(an), 16'(e_an));
    chk("digit_idx", 16'(digit_idx), 16'(e_idx));
    chk("upd_ack", 16'(upd_ack), 16'(e_ack));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] d, input logic [3:0] p);
    en = e; load = l; digits_in = d; dp_in = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (upd_ack) ack_cnt++;
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      seen = upd_ack;
    end
    chk(nm, 16'(seen), 16'd1);
  endtask

  initial begin
    logic [3:0] lit [$];
    logic [3:0] msk;
    logic [15:0] rd;
    logic seen;
    int acks0;

    tbl[0] = '{dig: 16'h1234, dp: 4'b0001, seg: {8'h9F, 8'h25, 8'h0D, 8'h98}};
    tbl[1] = '{dig: 16'h9876, dp: 4'b1010, seg: {8'h08, 8'h01, 8'h1E, 8'h41}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    tbl[2] = '{dig: 16'h00AF, dp: 4'b0000, seg: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[3] = '{dig: 16'h0040, dp: 4'b0100, seg: {8'hFF, 8'hFE, 8'h99, 8'h03}};
`else
    tbl[2] = '{dig: 16'h00AF, dp: 4'b0000, seg: {8'h03, 8'h03, 8'hFF, 8'hFF}};
    tbl[3] = '{dig: 16'h0040, dp: 4'b0100, seg: {8'h03, 8'h02, 8'h99, 8'h03}};
`endif
    tbl[4] = '{dig: 16'h5050, dp: 4'b0000, seg: {8'h49, 8'h03, 8'h49, 8'h03}};

    rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // scan order: ack at first frame end, then E,D,B,7 each after one blank cycle
    step(1'b1, 1'b1, 16'h1234, 4'b0001);
    wait_ack("first_ack");
    chk("ack_with_frame_done", 16'(frame_done), 16'd1);
    lit.delete();
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      if (i % DIV == 0) chk("slot_blank", 16'(an), 16'hF);
      if (an != 4'hF && (lit.size() == 0 || lit[$] != an)) lit.push_back(an);
    end
    chk("frame_period", 16'(frame_done), 16'd1);
    chk("lit_count", 16'(lit.size()), 16'd4);
    if (lit.size() == 4) begin
      chk("order0", 16'(lit[0]), 16'hE);
      chk("order1", 16'(lit[1]), 16'hD);
      chk("order2", 16'(lit[2]), 16'hB);
      chk("order3", 16'(lit[3]), 16'h7);
    end

    // tear-free: mid-frame load waits for the wrap, single ack
    repeat (6) step(1'b1, 1'b0, 16'h0, 4'h0);
    acks0 = ack_cnt;
    step(1'b1, 1'b1, 16'h5678, 4'b0000);
    repeat (2 * FRAME) step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("tearfree_acks", 16'(ack_cnt - acks0), 16'd1);

    // overwrite, second load lands in the wrap cycle
    repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
    acks0 = ack_cnt;
    step(1'b1, 1'b1, 16'h1111, 4'b0000);
    for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h2222, 4'b0000);
    chk("coinc_ack", 16'(upd_ack), 16'd1);
    seen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      if (an == 4'hE) begin seen = 1'b1; chk("coinc_digit0", 16'(seg), 16'h25); end
    end
    chk("coinc_digit0_lit", 16'(seen), 16'd1);
    chk("coinc_acks", 16'(ack_cnt - acks0), 16'd1);

    // invalid digit, then en drop mid-slot and restart at digit 0
    step(1'b1, 1'b1, 16'h00AF, 4'b0000);
    wait_ack("invalid_ack");
    seen = 1'b0;
    for (int i = 0; i < FRAME && !seen; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      if (an == 4'hD) seen = 1'b1;
    end
    chk("invalid_seen", 16'(seen), 16'd1);
    chk("invalid_seg", 16'(seg[7:1]), 16'h7F);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    chk("dis_an", 16'(an), 16'hF);
    chk("dis_idx", 16'(digit_idx), 16'd0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("restart_blank", 16'(an), 16'hF);
    chk("restart_idx", 16'(digit_idx), 16'd0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("restart_lit", 16'(an), 16'hE);

    // glyph table: load while dark, scan one frame
    for (int r = 0; r < 5; r++) begin
      step(1'b0, 1'b1, tbl[r].dig, tbl[r].dp);
      for (int c = 0; c < FRAME + 1; c++) begin
        step(1'b1, 1'b0, 16'h0, 4'h0);
        for (int d = 0; d < 4; d++) begin
          msk = ~(4'b0001 << d);
          if (an == msk) chk($sformatf("tbl%0d_d%0d", r, d), 16'(seg), 16'(tbl[r].seg[d]));
        end
      end
    end

    // reset mid-scan drops pending data
    step(1'b1, 1'b1, 16'h4321, 4'b1111);
    async_reset();
    acks0 = ack_cnt;
    repeat (2 * FRAME) step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("reset_drops_pending", 16'(ack_cnt - acks0), 16'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd = rd & 16'h00FF;
      if ($urandom_range(0, 3) == 0) rd = rd & 16'h000F;
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), rd, 4'($urandom));
      if (i == 400) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
